// File: rtl/conv_window_streamer.sv
// Buffers one raster-order image, then streams every KxK stride-1 window
// as a flattened word with valid/ready on both sides; repeats per frame.
module conv_window_streamer #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned IMG_X  = 28,
   parameter int unsigned IMG_Y  = 28,
   parameter int unsigned K      = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pix_valid,
   output logic                     pix_ready,
   input  logic [DATA_W-1:0]        pix_data,
   output logic                     win_valid,
   input  logic                     win_ready,
   output logic [K*K*DATA_W-1:0]    win_data,
   output logic [4:0]               win_row,
   output logic [4:0]               win_col,
   output logic                     frame_done
);

   localparam int unsigned OUT_X = IMG_X - K + 1;
   localparam int unsigned OUT_Y = IMG_Y - K + 1;
   localparam int unsigned AW_X  = $clog2(IMG_X);
   localparam int unsigned AW_Y  = $clog2(IMG_Y);

   localparam logic [0:0] ST_LOAD = 1'b0;
   localparam logic [0:0] ST_EMIT = 1'b1;

   logic [0:0]              state;
   logic [0:0]              state_next;
   logic [AW_X-1:0]         ld_row;
   logic [AW_Y-1:0]         ld_col;
   logic [DATA_W-1:0]       pix_buf [IMG_X][IMG_Y];

   logic                    pix_acc_c;
   logic                    last_pix_c;
   logic                    win_hs_c;
   logic                    last_win_c;
   logic                    load_win_c;
   logic [4:0]              row_next_c;
   logic [4:0]              col_next_c;
   logic [K*K*DATA_W-1:0]   win_next_c;

   // Handshake decode, next window position and next state
   always_comb begin
      state_next = state;
      row_next_c = win_row;
      col_next_c = win_col;

      pix_acc_c  = (state == ST_LOAD) && pix_valid && pix_ready;
      last_pix_c = pix_acc_c && (ld_row == AW_X'(IMG_X - 1)) && (ld_col == AW_Y'(IMG_Y - 1));
      win_hs_c   = (state == ST_EMIT) && win_valid && win_ready;
      last_win_c = win_hs_c && (win_row == 5'(OUT_X - 1)) && (win_col == 5'(OUT_Y - 1));
      load_win_c = last_pix_c || (win_hs_c && !last_win_c);

      if (last_pix_c) begin
         row_next_c = '0;
         col_next_c = '0;
      end else if (win_col == 5'(OUT_Y - 1)) begin
         row_next_c = win_row + 5'd1;
         col_next_c = '0;
      end else begin
         col_next_c = win_col + 5'd1;
      end

      case (state)
         ST_LOAD: if (last_pix_c) state_next = ST_EMIT;
         ST_EMIT: if (last_win_c) state_next = ST_LOAD;
         default: state_next = ST_LOAD;
      endcase
   end

   // Gather the next window; row/col + offset never exceeds the image edge
   always_comb begin
      win_next_c = '0;
      for (int i = 0; i < int'(K); i++) begin
         for (int j = 0; j < int'(K); j++) begin
            win_next_c[(i*K + j)*DATA_W +: DATA_W] =
               pix_buf[AW_X'(row_next_c) + AW_X'(i)][AW_Y'(col_next_c) + AW_Y'(j)];
         end
      end
   end

   // Pixel buffer has no reset; it is fully rewritten every frame
   always_ff @(posedge clk) begin
      if (!rst && pix_acc_c) begin
         pix_buf[ld_row][ld_col] <= pix_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_LOAD;
         ld_row     <= '0;
         ld_col     <= '0;
         pix_ready  <= 1'b0;
         win_valid  <= 1'b0;
         win_data   <= '0;
         win_row    <= '0;
         win_col    <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_next;
         pix_ready  <= (state_next == ST_LOAD);
         frame_done <= last_win_c;

         if (pix_acc_c) begin
            if (ld_col == AW_Y'(IMG_Y - 1)) begin
               ld_col <= '0;
               ld_row <= (ld_row == AW_X'(IMG_X - 1)) ? '0 : ld_row + AW_X'(1);
            end else begin
               ld_col <= ld_col + AW_Y'(1);
            end
         end

         if (load_win_c) begin
            win_valid <= 1'b1;
            win_data  <= win_next_c;
            win_row   <= row_next_c;
            win_col   <= col_next_c;
         end else if (last_win_c) begin
            win_valid <= 1'b0;
         end
      end
   end

endmodule
